// File: rtl/nna_mac_pkg.sv
// nna_mac_pkg
//   Shared definitions for the dot-product sequencer slice:
//   - state_t          : sequencer FSM state encoding
//   - DEF_*            : default widths
//   - SAT_MAX/SAT_MIN  : saturation limits of a w-bit signed value (w <= 63)
package nna_mac_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int unsigned DEF_DATA_W     = 8;
   localparam int unsigned DEF_ACC_W      = 24;
   localparam int unsigned DEF_LEN_W      = 8;
   localparam int unsigned DEF_APPROX_LSB = 4;

   function automatic longint SAT_MAX(input int unsigned w);
      return (longint'(1) <<< (w - 1)) - longint'(1);
   endfunction

   function automatic longint SAT_MIN(input int unsigned w);
      return -(longint'(1) <<< (w - 1));
   endfunction

endpackage

// File: rtl/sat_accumulator.sv
// sat_accumulator
//   Signed saturating accumulator. Each enabled cycle adds a sign-extended
//   product in ACC_W+1 bits; on overflow the register clamps to the
//   ACC_W-bit signed limit and the sticky sat flag is set.
//   Optional build macro APPROX_ACC_EN: zero the low APPROX_LSB product
//   bits before accumulation.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clr       : clear accumulator and sat (start of a job)
//   add_en    : accumulate product this cycle
//   product   : PROD_W-bit signed product
//   acc, sat  : accumulator value, sticky saturation flag
import nna_mac_pkg::*;

module sat_accumulator #(
   parameter int unsigned PROD_W     = 2 * DEF_DATA_W,
   parameter int unsigned ACC_W      = DEF_ACC_W,
   parameter int unsigned APPROX_LSB = DEF_APPROX_LSB
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              add_en,
   input  logic [PROD_W-1:0] product,
   output logic [ACC_W-1:0]  acc,
   output logic              sat
);

`ifdef APPROX_ACC_EN
   localparam bit APPROX_ON = 1'b1;
`else
   localparam bit APPROX_ON = 1'b0;
`endif

   localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(SAT_MAX(ACC_W));
   localparam logic [ACC_W-1:0] ACC_MIN = ACC_W'(SAT_MIN(ACC_W));

   logic [PROD_W-1:0] prod_eff;
   logic [ACC_W:0]    prod_ext;
   logic [ACC_W:0]    sum;
   logic              ovf;

   always_comb begin
      prod_eff = product;
      if (APPROX_ON) begin
         for (int unsigned i = 0; i < APPROX_LSB; i++) begin
            prod_eff[i] = 1'b0;
         end
      end
      prod_ext = {{(ACC_W + 1 - PROD_W){prod_eff[PROD_W-1]}}, prod_eff};
      sum      = {acc[ACC_W-1], acc} + prod_ext;
      // top two bits of the widened sum disagree only on signed overflow
      ovf      = sum[ACC_W] ^ sum[ACC_W-1];
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         acc <= '0;
         sat <= 1'b0;
      end else if (add_en) begin
         if (ovf) begin
            acc <= sum[ACC_W] ? ACC_MIN : ACC_MAX;
            sat <= 1'b1;
         end else begin
            acc <= sum[ACC_W-1:0];
         end
      end
   end

endmodule

// File: rtl/dot_product_sequencer.sv
// dot_product_sequencer
//   Sequences one signed dot-product job of len operand pairs through a
//   registered multiply stage into a saturating accumulator.
//   Build macro APPROX_ACC_EN (in sat_accumulator) selects truncated
//   accumulation; default build is exact.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   start, len            : job request (sampled in IDLE), pair count
//   busy                  : not IDLE
//   in_valid/in_ready     : operand handshake, in_a/in_b signed operands
//   out_valid/out_ready   : result handshake
//   out_data, out_sat     : result and sticky saturation flag
import nna_mac_pkg::*;

module dot_product_sequencer #(
   parameter int unsigned DATA_W     = DEF_DATA_W,
   parameter int unsigned ACC_W      = DEF_ACC_W,
   parameter int unsigned LEN_W      = DEF_LEN_W,
   parameter int unsigned APPROX_LSB = DEF_APPROX_LSB
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   output logic              busy,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_data,
   output logic              out_sat
);

   localparam int unsigned PROD_W = 2 * DATA_W;

   state_t            state;
   logic [LEN_W-1:0]  count;
   logic              p_valid;
   logic [PROD_W-1:0] p_data;
   logic [PROD_W-1:0] a_ext;
   logic [PROD_W-1:0] b_ext;
   logic [PROD_W-1:0] prod_c;
   logic              hs;
   logic              acc_clr;

   // low PROD_W bits of the product of sign-extended operands are the
   // exact signed product
   assign a_ext   = {{DATA_W{in_a[DATA_W-1]}}, in_a};
   assign b_ext   = {{DATA_W{in_b[DATA_W-1]}}, in_b};
   assign prod_c  = a_ext * b_ext;
   assign hs      = in_valid && in_ready;
   // every accepted start clears, so a len==0 job reports 0 / no saturation
   assign acc_clr = (state == IDLE) && start;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         count     <= '0;
         p_valid   <= 1'b0;
         p_data    <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         p_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  busy <= 1'b1;
                  if (len != '0) begin
                     count    <= len;
                     in_ready <= 1'b1;
                     state    <= RUN;
                  end else begin
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end
               end
            end
            RUN: begin
               if (hs) begin
                  p_data  <= prod_c;
                  p_valid <= 1'b1;
                  count   <= count - 1'b1;
                  if (count == LEN_W'(1)) begin
                     in_ready <= 1'b0;
                     state    <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               out_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // accumulator register doubles as the result register; it is frozen
   // from DONE until the next accepted start
   sat_accumulator #(
      .PROD_W    (PROD_W),
      .ACC_W     (ACC_W),
      .APPROX_LSB(APPROX_LSB)
   ) u_acc (
      .clk    (clk),
      .rst    (rst),
      .clr    (acc_clr),
      .add_en (p_valid),
      .product(p_data),
      .acc    (out_data),
      .sat    (out_sat)
   );

endmodule

// File: tb/tb_dot_product_sequencer.sv
module tb_dot_product_sequencer;

   localparam int DATA_W     = 8;
   localparam int ACC_W      = 16;
   localparam int LEN_W      = 8;
   localparam int APPROX_LSB = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [LEN_W-1:0]  len;
   logic              busy;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_a;
   logic [DATA_W-1:0] in_b;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  out_data;
   logic              out_sat;

   dot_product_sequencer #(
      .DATA_W    (DATA_W),
      .ACC_W     (ACC_W),
      .LEN_W     (LEN_W),
      .APPROX_LSB(APPROX_LSB)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .len      (len),
      .busy     (busy),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_a     (in_a),
      .in_b     (in_b),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_sat  (out_sat)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      longint data;
      bit     sat;
      int     due;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   hold_ready  = 1'b0;
   bit   force_ready = 1'b0;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: signed dot product with clamp after every add.
   function automatic void model(input int a_q[$], input int b_q[$],
                                 output longint acc, output bit sat);
      longint p;
      longint mx = (longint'(1) <<< (ACC_W - 1)) - 1;
      longint mn = -(longint'(1) <<< (ACC_W - 1));
      acc = 0;
      sat = 1'b0;
      foreach (a_q[i]) begin
         p = longint'(a_q[i]) * longint'(b_q[i]);
`ifdef APPROX_ACC_EN
         p = (p >>> APPROX_LSB) <<< APPROX_LSB;
`endif
         acc = acc + p;
         if (acc > mx) begin
            acc = mx;
            sat = 1'b1;
         end else if (acc < mn) begin
            acc = mn;
            sat = 1'b1;
         end
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // consumer
   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         out_ready = hold_ready ? 1'b0 :
                     (force_ready ? 1'b1 : ($urandom_range(0, 3) != 0));
      end
   end

   // monitor: compares each presented result with the scoreboard head
   initial begin
      bit     presented;
      longint hd;
      longint hsat;
      exp_t   e;
      presented = 1'b0;
      hd = 0;
      hsat = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            presented = 1'b0;
         end else if (out_valid) begin
            if (!presented) begin
               if (sb.size() == 0) begin
                  check("unexpected_out_valid", out_valid, 0);
               end else begin
                  e = sb[0];
                  check("out_data", longint'($signed(out_data)), e.data);
                  check("out_sat", out_sat, e.sat);
                  check("latency_cycle", cyc, e.due);
                  presented = 1'b1;
                  hd = longint'($signed(out_data));
                  hsat = out_sat;
               end
            end else begin
               check("hold_out_data", longint'($signed(out_data)), hd);
               check("hold_out_sat", out_sat, hsat);
            end
            if (out_ready && presented) begin
               void'(sb.pop_front());
               presented = 1'b0;
            end
         end
      end
   end

   task automatic send_pair(input int a, input int b, output int hs);
      in_valid = 1'b1;
      in_a = DATA_W'(a);
      in_b = DATA_W'(b);
      hs = -1;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (in_ready) begin
            hs = cyc;
            break;
         end
         tick();
      end
      if (hs < 0) check("handshake_timeout", in_ready, 1);
      tick();
      in_valid = 1'b0;
      in_a = DATA_W'($urandom);
      in_b = DATA_W'($urandom);
   endtask

   task automatic run_job(input int a_q[$], input int b_q[$], input int gap_q[$],
                          input bit hold);
      int     n;
      int     hs;
      int     c0;
      int     g;
      longint ea;
      bit     es;
      n = a_q.size();
      model(a_q, b_q, ea, es);
      hold_ready = hold;
      start = 1'b1;
      len = LEN_W'(n);
      @(negedge clk);
      c0 = cyc;
      tick();
      start = 1'b0;
      len = LEN_W'($urandom);
      if (n == 0) begin
         sb.push_back('{longint'(0), 1'b0, c0 + 1});
         for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("in_ready_len0", in_ready, 0);
            tick();
         end
      end else begin
         for (int i = 0; i < n; i++) begin
            if (i < gap_q.size()) g = gap_q[i];
            else g = ($urandom_range(0, 3) == 0) ? 1 : 0;
            repeat (g) begin
               in_valid = 1'b0;
               in_a = DATA_W'($urandom);
               in_b = DATA_W'($urandom);
               tick();
            end
            send_pair(a_q[i], b_q[i], hs);
            if (i == n - 1) sb.push_back('{ea, es, hs + 2});
         end
      end
      if (hold) begin
         for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid) break;
            tick();
         end
         tick();
         for (int i = 0; i < 5; i++) begin
            start = (i % 2 == 0);
            len = LEN_W'(1 + i);
            tick();
         end
         start = 1'b0;
         force_ready = 1'b1;
         hold_ready = 1'b0;
      end
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (!busy && sb.size() == 0) break;
         tick();
      end
      check("job_complete_busy", busy, 0);
      tick();
      if (hold) begin
         for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("start_ignored_busy", busy, 0);
            check("start_ignored_in_ready", in_ready, 0);
            tick();
         end
         force_ready = 1'b0;
      end
   endtask

   function automatic int rnd_op();
      case ($urandom_range(0, 5))
         0: return 127;
         1: return -128;
         default: return int'($urandom_range(0, 255)) - 128;
      endcase
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int qa[$];
      int qb[$];
      int qg[$];
      int hs;
      int n;
      rst = 1'b1;
      start = 1'b0;
      len = '0;
      in_valid = 1'b0;
      in_a = '0;
      in_b = '0;
      repeat (3) tick();
      rst = 1'b0;
      @(negedge clk);
      check("reset_busy", busy, 0);
      check("reset_in_ready", in_ready, 0);
      check("reset_out_valid", out_valid, 0);
      check("reset_out_data", out_data, 0);
      check("reset_out_sat", out_sat, 0);
      tick();

      // basic back-to-back job
      force_ready = 1'b1;
      qa = {2, -4, 7}; qb = {3, 5, 7}; qg = {0, 0, 0};
      run_job(qa, qb, qg, 1'b0);
      force_ready = 1'b0;

      // zero-length job
      qa.delete(); qb.delete(); qg.delete();
      run_job(qa, qb, qg, 1'b0);

      // positive saturation, then a fresh job clears the sticky flag
      qa = {127, 127, 127}; qb = {127, 127, 127};
      run_job(qa, qb, qg, 1'b0);
      qa = {-1}; qb = {1};
      run_job(qa, qb, qg, 1'b0);

      // negative saturation
      qa = {-128, -128, -128}; qb = {127, 127, 127};
      run_job(qa, qb, qg, 1'b0);

      // bubbles, consumer stall with start pulses in DONE
      qa = {9, -6}; qb = {-3, 11}; qg = {0, 2};
      run_job(qa, qb, qg, 1'b1);

      // reset mid-RUN after 2 of 4 pairs
      start = 1'b1;
      len = LEN_W'(4);
      tick();
      start = 1'b0;
      send_pair(1, 2, hs);
      send_pair(3, 4, hs);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("midrun_rst_busy", busy, 0);
      check("midrun_rst_in_ready", in_ready, 0);
      check("midrun_rst_out_valid", out_valid, 0);
      check("midrun_rst_out_data", out_data, 0);
      check("midrun_rst_out_sat", out_sat, 0);
      tick();
      qa = {1, 2}; qb = {1, 2}; qg.delete();
      run_job(qa, qb, qg, 1'b0);

      // truncation-sensitive job (exact 31, approximate 16)
      qa = {3, 4}; qb = {5, 4};
      run_job(qa, qb, qg, 1'b0);

      // randomized jobs
      for (int j = 0; j < 20; j++) begin
         qa.delete(); qb.delete();
         n = $urandom_range(0, 8);
         for (int i = 0; i < n; i++) begin
            qa.push_back(rnd_op());
            qb.push_back(rnd_op());
         end
         run_job(qa, qb, qg, 1'b0);
      end

      repeat (5) tick();
      check("scoreboard_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
